// File: rtl/stim_pkg.sv
// rtl/stim_pkg.sv - shared types and constants for the biphasic pulse sequencer
//
// Contents:
//   stim_state_t       sequencer state encoding (IDLE=0, PH1=1, GAP=2, PH2=3)
//   OVERRUN_CNT_W      width of the dropped-tick counter
//   POL_CATHODIC_FIRST polarity value that puts phase 1 on drive_n
package stim_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PH1  = 2'd1,
        GAP  = 2'd2,
        PH2  = 2'd3
    } stim_state_t;

    localparam int   OVERRUN_CNT_W      = 16;
    localparam logic POL_CATHODIC_FIRST = 1'b0;

endpackage

// File: rtl/stim_phase_counter.sv
// rtl/stim_phase_counter.sv - loadable down-counter timing one sequencer phase
//
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   load       load value into the counter this edge (wins over counting)
//   value      length-1 of the phase being entered
//   zero       count has reached 0 (last cycle of the current phase)
module stim_phase_counter
    import stim_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    // Holds at 0 once expired so an idle sequencer sees a stable zero flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/stim_pulse_seq.sv
// rtl/stim_pulse_seq.sv - biphasic charge-balanced stimulation pulse sequencer
//
// Each accepted tick runs PH1 -> GAP -> PH2 using lengths captured at the tick;
// zero-length phases are skipped without costing a cycle.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   enable                       accept new ticks when high
//   tick                         single-cycle pulse start request
//   polarity                     0: phase 1 on drive_n, 1: phase 1 on drive_p
//   phase1_len/gap_len/phase2_len  phase durations in cycles
//   drive_p, drive_n             registered electrode switch enables
//   busy                         sequencer not idle
//   done                         one-cycle pulse in the first idle cycle after a pulse
//   overrun                      one-cycle pulse when a tick is dropped
//   overrun_cnt                  saturating dropped-tick count
//
// Build option: STIM_SEQ_OVERRUN_CNT_EN implements overrun_cnt; otherwise it is 0.
module stim_pulse_seq
    import stim_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     tick,
    input  logic                     polarity,
    input  logic [WIDTH-1:0]         phase1_len,
    input  logic [WIDTH-1:0]         gap_len,
    input  logic [WIDTH-1:0]         phase2_len,
    output logic                     drive_p,
    output logic                     drive_n,
    output logic                     busy,
    output logic                     done,
    output logic                     overrun,
    output logic [OVERRUN_CNT_W-1:0] overrun_cnt
);

    stim_state_t      state;
    stim_state_t      state_nxt;

    // Phase-1 length is only needed at entry, where it comes straight from
    // the input; the counter then carries it, so no shadow copy is kept.
    logic             sh_pol;
    logic [WIDTH-1:0] sh_gap;
    logic [WIDTH-1:0] sh_ph2;

    logic             accept;
    logic             pol_sel;
    logic [WIDTH-1:0] gap_sel;
    logic [WIDTH-1:0] ph2_sel;
    logic             cnt_load;
    logic [WIDTH-1:0] cnt_value;
    logic             cnt_zero;
    logic             done_nxt;

    stim_phase_counter #(.WIDTH(WIDTH)) u_phase_counter (
        .clk   (clk),
        .rst   (rst),
        .load  (cnt_load),
        .value (cnt_value),
        .zero  (cnt_zero)
    );

    always_comb begin
        accept    = (state == IDLE) && tick && enable;
        // On the accepting edge the shadows are not yet written, so decode
        // from the live inputs; afterwards only the shadows are used.
        pol_sel   = accept ? polarity   : sh_pol;
        gap_sel   = accept ? gap_len    : sh_gap;
        ph2_sel   = accept ? phase2_len : sh_ph2;

        state_nxt = state;
        cnt_load  = 1'b0;
        cnt_value = '0;
        done_nxt  = 1'b0;

        case (state)
            IDLE: begin
                if (accept) begin
                    if (phase1_len != '0) begin
                        state_nxt = PH1;
                        cnt_load  = 1'b1;
                        cnt_value = phase1_len - WIDTH'(1);
                    end else if (gap_sel != '0) begin
                        state_nxt = GAP;
                        cnt_load  = 1'b1;
                        cnt_value = gap_sel - WIDTH'(1);
                    end else if (ph2_sel != '0) begin
                        state_nxt = PH2;
                        cnt_load  = 1'b1;
                        cnt_value = ph2_sel - WIDTH'(1);
                    end else begin
                        done_nxt  = 1'b1;
                    end
                end
            end
            PH1: begin
                if (cnt_zero) begin
                    if (gap_sel != '0) begin
                        state_nxt = GAP;
                        cnt_load  = 1'b1;
                        cnt_value = gap_sel - WIDTH'(1);
                    end else if (ph2_sel != '0) begin
                        state_nxt = PH2;
                        cnt_load  = 1'b1;
                        cnt_value = ph2_sel - WIDTH'(1);
                    end else begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end
            end
            GAP: begin
                if (cnt_zero) begin
                    if (ph2_sel != '0) begin
                        state_nxt = PH2;
                        cnt_load  = 1'b1;
                        cnt_value = ph2_sel - WIDTH'(1);
                    end else begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end
            end
            default: begin
                if (cnt_zero) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
        endcase
    end

    // Drives are decoded from the next state so they line up with it; the
    // two terms are mutually exclusive, so both lines can never be high.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            drive_p <= 1'b0;
            drive_n <= 1'b0;
            done    <= 1'b0;
            overrun <= 1'b0;
            sh_pol  <= 1'b0;
            sh_gap  <= '0;
            sh_ph2  <= '0;
        end else begin
            state   <= state_nxt;
            drive_p <= ((state_nxt == PH1) && (pol_sel != POL_CATHODIC_FIRST)) ||
                       ((state_nxt == PH2) && (pol_sel == POL_CATHODIC_FIRST));
            drive_n <= ((state_nxt == PH1) && (pol_sel == POL_CATHODIC_FIRST)) ||
                       ((state_nxt == PH2) && (pol_sel != POL_CATHODIC_FIRST));
            done    <= done_nxt;
            overrun <= tick && !accept;
            if (accept) begin
                sh_pol <= polarity;
                sh_gap <= gap_len;
                sh_ph2 <= phase2_len;
            end
        end
    end

    assign busy = (state != IDLE);

`ifdef STIM_SEQ_OVERRUN_CNT_EN
    logic [OVERRUN_CNT_W-1:0] ovr_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ovr_cnt_q <= '0;
        end else if (tick && !accept && (ovr_cnt_q != '1)) begin
            ovr_cnt_q <= ovr_cnt_q + OVERRUN_CNT_W'(1);
        end
    end

    assign overrun_cnt = ovr_cnt_q;
`else
    assign overrun_cnt = '0;
`endif

endmodule

// File: tb/tb_stim_pulse_seq.sv
// tb/tb_stim_pulse_seq.sv - scoreboard bench for stim_pulse_seq
module tb_stim_pulse_seq;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          tick;
    logic          polarity;
    logic [W-1:0]  phase1_len;
    logic [W-1:0]  gap_len;
    logic [W-1:0]  phase2_len;
    logic          drive_p;
    logic          drive_n;
    logic          busy;
    logic          done;
    logic          overrun;
    logic [15:0]   overrun_cnt;

    always #5 clk = ~clk;

    stim_pulse_seq #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .tick        (tick),
        .polarity    (polarity),
        .phase1_len  (phase1_len),
        .gap_len     (gap_len),
        .phase2_len  (phase2_len),
        .drive_p     (drive_p),
        .drive_n     (drive_n),
        .busy        (busy),
        .done        (done),
        .overrun     (overrun),
        .overrun_cnt (overrun_cnt)
    );

    typedef struct {
        int start;
        int l1;
        int g;
        int l2;
        bit pol;
    } pulse_t;

    typedef struct {
        int cyc;
        int cnt;
    } ovr_t;

    pulse_t pulse_q[$];
    ovr_t   ovr_q[$];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks    = 0;
    int failures  = 0;
    int free_at   = 0;
    int ovr_model = 0;
    int inv_bad   = 0;
    bit mon_on    = 1'b0;

    bit dp_h[int];
    bit dn_h[int];
    bit busy_h[int];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int exp_cnt(input int n);
`ifdef STIM_SEQ_OVERRUN_CNT_EN
        return (n > 65535) ? 65535 : n;
`else
        return 0;
`endif
    endfunction

    // Reference model: a tick is taken iff enabled and the previous pulse's
    // done cycle has been reached; otherwise it is an overrun.
    task automatic step(input bit t, input bit en, input bit pol, input int a, input int b, input int c);
        pulse_t p;
        ovr_t   o;
        tick       = t;
        enable     = en;
        polarity   = pol;
        phase1_len = a[W-1:0];
        gap_len    = b[W-1:0];
        phase2_len = c[W-1:0];
        if (t) begin
            if (en && cyc >= free_at) begin
                p.start = cyc + 1;
                p.l1    = a;
                p.g     = b;
                p.l2    = c;
                p.pol   = pol;
                pulse_q.push_back(p);
                free_at = cyc + a + b + c + 1;
            end else begin
                ovr_model++;
                o.cyc = cyc + 1;
                o.cnt = exp_cnt(ovr_model);
                ovr_q.push_back(o);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 1, 0, 0, 0, 0);
    endtask

    task automatic check_pulse(input pulse_t p);
        int len;
        int bad;
        int c;
        bit ep;
        bit en;
        len = p.l1 + p.g + p.l2;
        bad = 0;
        check("done_cycle", cyc, p.start + len);
        for (int k = 0; k < len; k++) begin
            c = p.start + k;
            if (k < p.l1) begin
                ep = p.pol;
                en = !p.pol;
            end else if (k < p.l1 + p.g) begin
                ep = 0;
                en = 0;
            end else begin
                ep = !p.pol;
                en = p.pol;
            end
            if (!dp_h.exists(c)) bad++;
            else if (dp_h[c] != ep || dn_h[c] != en || busy_h[c] != 1'b1) bad++;
        end
        if (drive_p !== 1'b0 || drive_n !== 1'b0 || busy !== 1'b0) bad++;
        check("pulse_shape_bad_cycles", bad, 0);
    endtask

    initial begin
        pulse_t mp;
        ovr_t   mo;
        forever begin
            @(negedge clk);
            if (mon_on) begin
                dp_h[cyc]   = drive_p;
                dn_h[cyc]   = drive_n;
                busy_h[cyc] = busy;
                if (drive_p === 1'b1 && drive_n === 1'b1) inv_bad++;
                if (done === 1'b1) begin
                    if (pulse_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL done_unexpected: got done=1 expected no pulse pending (cycle %0d)", cyc);
                    end else begin
                        mp = pulse_q.pop_front();
                        check_pulse(mp);
                    end
                end
                if (overrun === 1'b1) begin
                    if (ovr_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL overrun_unexpected: got overrun=1 expected 0 (cycle %0d)", cyc);
                    end else begin
                        mo = ovr_q.pop_front();
                        check("overrun_cycle", cyc, mo.cyc);
                        check("overrun_cnt", overrun_cnt, mo.cnt);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        rst        = 1'b1;
        tick       = 1'b0;
        enable     = 1'b0;
        polarity   = 1'b0;
        phase1_len = '0;
        gap_len    = '0;
        phase2_len = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_outputs", {drive_p, drive_n, busy, done, overrun}, 0);
        check("reset_overrun_cnt", overrun_cnt, 0);
        @(posedge clk);
        #1;
        mon_on = 1'b1;

        // nominal cathodic-first 4/2/4
        step(1, 1, 0, 4, 2, 4);
        idle(12);
        // zero gap, anodic-first
        step(1, 1, 1, 3, 0, 3);
        idle(8);
        // empty pulse
        step(1, 1, 0, 0, 0, 0);
        idle(2);
        // overrun at T+3, then back-to-back tick coincident with done (T+12)
        step(1, 1, 0, 5, 1, 5);
        idle(2);
        step(1, 1, 0, 5, 1, 5);
        idle(8);
        step(1, 1, 1, 2, 1, 2);
        idle(8);
        // enable falls at T+2; later tick is dropped
        step(1, 1, 0, 4, 2, 4);
        step(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) step(0, 0, 0, 0, 0, 0);
        step(1, 0, 1, 3, 3, 3);
        idle(3);
        // inputs change mid-pulse
        step(1, 1, 0, 4, 2, 4);
        step(0, 1, 0, 4, 2, 4);
        step(0, 1, 0, 4, 2, 4);
        for (int i = 0; i < 10; i++) step(0, 1, 1, 7, 5, 9);
        idle(2);

        // randomized traffic
        for (int i = 0; i < 40; i++) begin
            int gapc;
            gapc = $urandom_range(0, 12);
            step(1, ($urandom_range(0, 9) != 0), $urandom_range(0, 1),
                 $urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 6));
            for (int j = 0; j < gapc; j++)
                step(0, $urandom_range(0, 1), $urandom_range(0, 1),
                     $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
        end

        guard = 0;
        while ((pulse_q.size() != 0 || ovr_q.size() != 0) && guard < 300) begin
            idle(1);
            guard++;
        end
        idle(1);
        check("drain_pulse_q", pulse_q.size(), 0);
        check("drain_ovr_q", ovr_q.size(), 0);
        check("drive_exclusive_violations", inv_bad, 0);

        // reset asserted at T+5 of a 4/2/4 pulse
        step(1, 1, 0, 4, 2, 4);
        idle(4);
        mon_on = 1'b0;
        rst    = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_mid_outputs", {drive_p, drive_n, busy, done, overrun}, 0);
        check("reset_mid_overrun_cnt", overrun_cnt, 0);
        pulse_q.delete();
        ovr_q.delete();
        free_at   = 0;
        ovr_model = 0;
        @(posedge clk);
        #1;
        mon_on = 1'b1;

        // sequencer recovers cleanly after reset
        step(1, 1, 1, 2, 2, 2);
        idle(10);
        check("post_reset_pulse_q", pulse_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
